// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared types and constants for the boot loader
package imem_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         LEN_BITS  = 16;

endpackage

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - instruction-memory write port and core control/status
interface imem_boot_loader_if #(
    parameter int WIDTH = 32
);
    logic             insMemEn;
    logic [WIDTH-1:0] insMemAddr;
    logic [WIDTH-1:0] insMemDataIn;
    logic             cpu_reset;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        output insMemEn, insMemAddr, insMemDataIn, cpu_reset, busy, done, error
    );

    modport slave (
        input insMemEn, insMemAddr, insMemDataIn, cpu_reset, busy, done, error
    );
endinterface

// File: rtl/imem_boot_loader_uart_rx.sv
// rtl/imem_boot_loader_uart_rx.sv - 8N1 UART byte receiver on an already synchronized rx
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_sync,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          prev_q, valid_d, ferr_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            prev_q     <= 1'b1;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            prev_q     <= rx_sync;
            byte_valid <= valid_d;
            frame_err  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = frame_err;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_sync) state_d = RX_START;
            end
            // A start bit that is high again at mid-bit was only a glitch.
            RX_START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx_sync ? RX_IDLE : RX_BITS;
            end
            RX_BITS: if (cnt_q == FULL) begin
                cnt_d   = '0;
                shift_d = {rx_sync, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == FULL) begin
                state_d = RX_IDLE;
                valid_d = 1'b1;
                ferr_d  = !rx_sync;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_data = shift_q;
endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - UART program-image loader writing the core instruction memory
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int IMEM_DEPTH   = 512,
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rx,
    imem_boot_loader_if.master  bus
);
    localparam int IDX_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

    logic rx_meta, rx_sync;
    logic byte_valid, frame_err;
    logic [7:0] byte_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock      (clock),
        .reset      (reset),
        .rx_sync    (rx_sync),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    loader_state_t       state_q, state_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic [IDX_W-1:0]    idx_q, idx_d, addr_q, addr_d;
    logic [1:0]          k_q, k_d;
    logic [23:0]         asm_q, asm_d;
    logic [7:0]          csum_q, csum_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                en_q, en_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                busy_st;

    assign busy_st = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                     (state_q == DATA)   || (state_q == CHECK);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            k_q     <= '0;
            asm_q   <= '0;
            csum_q  <= '0;
            tmo_q   <= '0;
            en_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            k_q     <= k_d;
            asm_q   <= asm_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
            en_q    <= en_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        k_d     = k_q;
        asm_d   = asm_q;
        csum_d  = csum_q;
        en_d    = 1'b0;
        data_d  = data_q;
        tmo_d   = (busy_st && !byte_valid) ? tmo_q + TMO_W'(1) : '0;

        if (!busy_st) begin
            if (byte_valid && !frame_err && byte_data == SYNC_BYTE) begin
                state_d = LEN_LO;
                idx_d   = '0;
                k_d     = '0;
                asm_d   = '0;
                csum_d  = '0;
            end
        end else if (byte_valid && frame_err) begin
            state_d = ERROR;
        end else if (byte_valid) begin
            case (state_q)
                LEN_LO: begin
                    len_d[7:0] = byte_data;
                    state_d    = LEN_HI;
                end
                LEN_HI: begin
                    len_d = {byte_data, len_q[7:0]};
                    if (len_d == '0 || 32'(len_d) > 32'(IMEM_DEPTH)) state_d = ERROR;
                    else                                             state_d = DATA;
                end
                DATA: begin
                    csum_d = csum_q ^ byte_data;
                    k_d    = k_q + 2'd1;
                    // The 4th byte goes straight into the write data; only 3 bytes are ever buffered.
                    if (k_q == 2'd3) begin
                        en_d   = 1'b1;
                        addr_d = idx_q;
                        data_d = WIDTH'({byte_data, asm_q});
                        asm_d  = '0;
                        idx_d  = idx_q + IDX_W'(1);
                        if (LEN_BITS'(idx_q) == len_q - LEN_BITS'(1)) state_d = CHECK;
                    end else begin
                        asm_d = asm_q | (24'(byte_data) << {k_q, 3'b000});
                    end
                end
                CHECK: state_d = (byte_data == csum_q) ? DONE : ERROR;
                default: state_d = IDLE;
            endcase
        end else if (tmo_q == TMO_W'(TIMEOUT_CLKS - 1)) begin
            state_d = ERROR;
        end
    end

    assign bus.insMemEn     = en_q;
    assign bus.insMemAddr   = WIDTH'(addr_q);
    assign bus.insMemDataIn = data_q;
    assign bus.cpu_reset    = (state_q != DONE);
    assign bus.busy         = busy_st;
    assign bus.done         = (state_q == DONE);
    assign bus.error        = (state_q == ERROR);
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
module tb_imem_boot_loader;
    localparam int WIDTH = 32;
    localparam int DEPTH = 512;
    localparam int CPB   = 4;
    localparam int TMO   = 200;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;

    always #5 clock = ~clock;

    imem_boot_loader_if #(.WIDTH(WIDTH)) bus ();

    imem_boot_loader #(
        .WIDTH(WIDTH), .IMEM_DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    typedef struct {
        int len;
        bit bad;
        bit exp_done;
        bit exp_err;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  frame[$];
    logic [63:0] got_w[$];
    logic [63:0] exp_w[$];
    vec_t        vecs[6];

    always @(negedge clock) if (bus.insMemEn) got_w.push_back({bus.insMemAddr, bus.insMemDataIn});

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clock);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clock);
    endtask

    task automatic send_frame();
        foreach (frame[i]) send_byte(frame[i], 1'b1);
        repeat (2) @(negedge clock);
    endtask

    task automatic build_frame(input int len, input bit bad);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        frame.delete();
        frame.push_back(8'hA5);
        frame.push_back(len[7:0]);
        frame.push_back(len[15:8]);
        if (len >= 1 && len <= DEPTH) begin
            for (int i = 0; i < 4 * len; i++) begin
                b = 8'($urandom);
                frame.push_back(b);
                cs ^= b;
            end
            frame.push_back(bad ? ~cs : cs);
        end
    endtask

    // Reference: decode the frame as little-endian words and judge the checksum.
    task automatic model_frame(output bit m_done, output bit m_err);
        int         len;
        logic [7:0] x;
        logic [31:0] w;
        exp_w.delete();
        len    = {frame[2], frame[1]};
        m_done = 1'b0;
        m_err  = 1'b1;
        if (len >= 1 && len <= DEPTH) begin
            x = 8'h00;
            for (int i = 0; i < len; i++) begin
                w = {frame[6 + 4*i], frame[5 + 4*i], frame[4 + 4*i], frame[3 + 4*i]};
                x ^= w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
                exp_w.push_back({32'(i), w});
            end
            m_done = (frame[3 + 4*len] == x);
            m_err  = !m_done;
        end
    endtask

    task automatic check_result(input string name, input bit e_done, input bit e_err);
        check({name, ".writes"}, 64'(got_w.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            check($sformatf("%s.wr%0d", name, i), got_w[i], exp_w[i]);
        check({name, ".done"}, 64'(bus.done), 64'(e_done));
        check({name, ".error"}, 64'(bus.error), 64'(e_err));
        check({name, ".busy"}, 64'(bus.busy), 64'(0));
        check({name, ".cpu_reset"}, 64'(bus.cpu_reset), 64'(!e_done));
        if (exp_w.size() > 0) begin
            check({name, ".hold"}, {bus.insMemAddr, bus.insMemDataIn}, exp_w[exp_w.size() - 1]);
        end
    endtask

    task automatic fixed_frame(input logic [7:0] cs_byte);
        frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'hB3, 8'h00, 8'h50, 8'h00, 8'h00};
        frame[11] = cs_byte;
        exp_w = '{{32'd0, 32'h0000_0013}, {32'd1, 32'h0050_00B3}};
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".en"},   64'(bus.insMemEn), 64'(0));
        check({name, ".addr"}, 64'(bus.insMemAddr), 64'(0));
        check({name, ".data"}, 64'(bus.insMemDataIn), 64'(0));
        check({name, ".ctl"},  64'({bus.cpu_reset, bus.busy, bus.done, bus.error}), 64'(4'b1000));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit md, me;

        vecs[0] = '{1,   1'b0, 1'b1, 1'b0};
        vecs[1] = '{2,   1'b1, 1'b0, 1'b1};
        vecs[2] = '{3,   1'b0, 1'b1, 1'b0};
        vecs[3] = '{0,   1'b0, 1'b0, 1'b1};
        vecs[4] = '{513, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{4,   1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check_reset_outputs("idle");

        got_w.delete();
        fixed_frame(8'hF0);
        send_frame();
        check_result("good_load", 1'b1, 1'b0);

        got_w.delete();
        fixed_frame(8'h00);
        send_frame();
        check_result("bad_csum", 1'b0, 1'b1);

        got_w.delete();
        exp_w.delete();
        frame = '{8'hA5, 8'h00, 8'h00};
        send_frame();
        check_result("len_zero", 1'b0, 1'b1);
        frame = '{8'hA5, 8'h01, 8'h02};
        send_frame();
        check_result("len_513", 1'b0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            got_w.delete();
            build_frame(vecs[i].len, vecs[i].bad);
            model_frame(md, me);
            send_frame();
            check_result($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_err);
        end

        for (int i = 0; i < 4; i++) begin
            got_w.delete();
            build_frame($urandom_range(1, 3), ($urandom_range(0, 3) == 0));
            model_frame(md, me);
            send_frame();
            check_result($sformatf("rand%0d", i), md, me);
        end

        // Noise in front of a load: non-sync bytes and a 1-cycle glitch are ignored.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        got_w.delete();
        send_byte(8'h55, 1'b1);
        send_byte(8'hFF, 1'b1);
        rx = 1'b0;
        @(negedge clock);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clock);
        check("noise.ctl", 64'({bus.cpu_reset, bus.busy, bus.done, bus.error}), 64'(4'b1000));
        fixed_frame(8'hF0);
        send_frame();
        check_result("after_noise", 1'b1, 1'b0);

        // A fresh sync byte while running puts the core back into reset.
        frame = '{8'hA5};
        send_frame();
        check("resync.ctl", 64'({bus.cpu_reset, bus.busy, bus.done, bus.error}), 64'(4'b1100));

        // Inter-byte timeout mid-word.
        got_w.delete();
        frame = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00};
        send_frame();
        repeat (150) @(negedge clock);
        check("tmo.early", 64'({bus.busy, bus.error}), 64'(2'b10));
        repeat (100) @(negedge clock);
        check("tmo.late", 64'({bus.cpu_reset, bus.busy, bus.done, bus.error}), 64'(4'b1001));
        check("tmo.writes", 64'(got_w.size()), 64'(0));
        got_w.delete();
        fixed_frame(8'hF0);
        send_frame();
        check_result("after_tmo", 1'b1, 1'b0);

        // Framing error inside DATA.
        got_w.delete();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
        send_frame();
        send_byte(8'h00, 1'b0);
        repeat (2) @(negedge clock);
        check("ferr.ctl", 64'({bus.cpu_reset, bus.busy, bus.done, bus.error}), 64'(4'b1001));
        check("ferr.writes", 64'(got_w.size()), 64'(0));
        check("ferr.hold", {bus.insMemAddr, bus.insMemDataIn}, {32'd1, 32'h0050_00B3});

        // Reset in the middle of the last byte of a word.
        got_w.delete();
        frame = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00};
        send_frame();
        fork
            send_byte(8'h00, 1'b1);
            begin
                repeat (10) @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                check_reset_outputs("mid_reset");
                reset = 1'b0;
            end
        join
        repeat (4 * CPB) @(negedge clock);
        check("mid_reset.writes", 64'(got_w.size()), 64'(0));
        check("mid_reset.idle", 64'({bus.cpu_reset, bus.busy, bus.done, bus.error}), 64'(4'b1000));
        got_w.delete();
        fixed_frame(8'hF0);
        send_frame();
        check_result("after_reset", 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
